// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: controller state encoding, M-extension funct3 codes and default latency limit
package muldiv_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;
  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;
  localparam int MAX_LAT_DEF = 40;
endpackage

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences M-extension ops through an external mul/div unit, with divide-by-zero shortcut and a one-entry result cache
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LAT    = MAX_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic                  flush_i,
  input  logic                  hold_i,
  output logic                  mdu_start_o,
  output logic [2:0]            mdu_funct3_o,
  output logic [DATA_WIDTH-1:0] mdu_rs1_o,
  output logic [DATA_WIDTH-1:0] mdu_rs2_o,
  input  logic                  mdu_busy_i,
  input  logic [DATA_WIDTH-1:0] mdu_result_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  valid_o,
  output logic                  stall_o,
  output logic                  timeout_o
);
  localparam int CW = $clog2(MAX_LAT + 1);
  state_t state, state_nx;
  logic busy_seen, drain_seen, cache_vld;
  logic [CW-1:0] cnt;
  logic [2:0] cache_f3;
  logic [DATA_WIDTH-1:0] res_q, cache_rs1, cache_rs2, cache_res, sc_res;
  logic sc, hit, fast, done_ok, tmo;
  always_comb begin
    sc = (funct3_i inside {F_DIV, F_DIVU, F_REM, F_REMU}) && rs2_i == '0;
    sc_res = (funct3_i inside {F_REM, F_REMU}) ? rs1_i : '1;
    hit = cache_vld && cache_f3 == funct3_i && cache_rs1 == rs1_i && cache_rs2 == rs2_i;
    fast = state == S_IDLE && req_i && (sc || hit);
    done_ok = busy_seen && !mdu_busy_i;
    tmo = !done_ok && cnt == CW'(MAX_LAT - 1);
    mdu_start_o = state == S_ISSUE;
    valid_o = state == S_DONE || (fast && !flush_i);
    stall_o = req_i && state != S_DONE && !fast;
    result_o = state == S_IDLE ? (sc ? sc_res : hit ? cache_res : res_q) : res_q;
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = (req_i && !flush_i && !sc && !hit) ? S_ISSUE : S_IDLE;
      S_ISSUE: state_nx = flush_i ? S_DRAIN : S_WAIT;
      S_WAIT:  state_nx = flush_i ? (mdu_busy_i ? S_DRAIN : S_IDLE) : (done_ok || tmo) ? S_DONE : S_WAIT;
      S_DRAIN: state_nx = (drain_seen && !mdu_busy_i) ? S_IDLE : S_DRAIN;
      S_DONE:  state_nx = (hold_i && !flush_i) ? S_DONE : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  // cache and result capture only on a genuine completion; timeouts return zero uncached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      mdu_funct3_o <= '0;
      mdu_rs1_o    <= '0;
      mdu_rs2_o    <= '0;
      res_q        <= '0;
      busy_seen    <= 1'b0;
      drain_seen   <= 1'b0;
      cnt          <= '0;
      timeout_o    <= 1'b0;
      cache_vld    <= 1'b0;
      cache_f3     <= '0;
      cache_rs1    <= '0;
      cache_rs2    <= '0;
      cache_res    <= '0;
    end else begin
      state      <= state_nx;
      busy_seen  <= state == S_WAIT && (busy_seen || mdu_busy_i);
      drain_seen <= state == S_DRAIN;
      cnt        <= state == S_WAIT ? cnt + CW'(1) : '0;
      timeout_o  <= state == S_WAIT && !flush_i && tmo;
      if (state == S_IDLE && state_nx == S_ISSUE) begin
        mdu_funct3_o <= funct3_i;
        mdu_rs1_o    <= rs1_i;
        mdu_rs2_o    <= rs2_i;
      end
      if (state == S_WAIT && state_nx == S_DONE) begin
        res_q <= done_ok ? mdu_result_i : '0;
        if (done_ok) begin
          cache_vld <= 1'b1;
          cache_f3  <= mdu_funct3_o;
          cache_rs1 <= mdu_rs1_o;
          cache_rs2 <= mdu_rs2_o;
          cache_res <= mdu_result_i;
        end
      end
    end
  end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand/result width.
REQ-002 SHALL have parameter MAX_LAT, default 40: WAIT-state cycle limit before timeout.
REQ-003 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-005 SHALL have port req_i  in  1: execute stage holds an M-extension op.
REQ-006 SHALL have port funct3_i  in  3: M op select (MUL..REMU).
REQ-007 SHALL have ports rs1_i, rs2_i  in  DATA_WIDTH each: operands.
REQ-008 SHALL have port flush_i  in  1: kill in-flight op.
REQ-009 SHALL have port hold_i  in  1: downstream stall; result must be held.
REQ-010 SHALL have ports mdu_start_o  out  1, mdu_funct3_o  out  3, mdu_rs1_o, mdu_rs2_o  out  DATA_WIDTH: unit command, operands registered.
REQ-011 SHALL have ports mdu_busy_i  in  1, mdu_result_i  in  DATA_WIDTH: unit status/result.
REQ-012 SHALL have ports result_o  out  DATA_WIDTH, valid_o  out  1, stall_o  out  1, timeout_o  out  1.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT, DRAIN, DONE.
REQ-014 IDLE, req_i=1, no shortcut/hit: latch funct3/rs1/rs2 into mdu_* regs, go ISSUE.
REQ-015 ISSUE: mdu_start_o=1 exactly one cycle, clear busy_seen and cycle counter, go WAIT.
REQ-016 WAIT: set busy_seen when mdu_busy_i=1; when busy_seen=1 and mdu_busy_i=0, capture mdu_result_i into result reg, go DONE.
REQ-017 WAIT: counter increments each cycle; at MAX_LAT without completion, result reg=0, timeout_o=1 for one cycle, go DONE.
REQ-018 DONE: valid_o=1, result_o=result reg; stay while hold_i=1; go IDLE when hold_i=0.
REQ-019 stall_o = req_i AND NOT(state=DONE) AND NOT(IDLE shortcut/hit), combinational.
REQ-020 Divide-by-zero shortcut in IDLE (rs2_i=0): DIV/DIVU result all-ones, REM/REMU result rs1_i; valid_o=1 same cycle, no mdu_start_o.
REQ-021 Result cache: on capture, store {funct3, rs1, rs2, result}, tag valid; in IDLE, req_i with exact tag match gives valid_o=1, result_o=cached, same cycle, no start.
REQ-022 Shortcut takes precedence over cache hit; neither updates the cache.
REQ-023 flush_i in ISSUE or WAIT: go DRAIN if mdu_busy_i=1 or state=ISSUE, else IDLE; cache not updated.
REQ-024 DRAIN: stall_o=1 for any req_i; go IDLE when mdu_busy_i=0 and at least one cycle elapsed.
REQ-025 flush_i in DONE: go IDLE; flush_i in IDLE suppresses shortcut/hit valid_o.
REQ-026 Timeout result SHALL NOT be cached.
REQ-027 valid_o SHALL never be 1 in ISSUE, WAIT or DRAIN.

Reset
REQ-028 rst=1 SHALL force IDLE; mdu_start_o, valid_o, stall-related regs, timeout_o=0; mdu_* operand regs, result reg, cache data=0; cache tag invalid; counter=0.
REQ-029 rst mid-operation SHALL abandon op immediately; no DRAIN.

Structure
REQ-030 State encodings, M funct3 codes and MAX_LAT default SHALL live in the shared defines header.
REQ-031 Single module; no sub-module; the M unit is instantiated by the parent next to this controller.

Verification
REQ-032 MUL 7*6, unit busy 3 cycles -> start pulse once, stall_o=1 until DONE, result_o=42, valid_o=1 one cycle.
REQ-033 DIVU 100/0 -> same-cycle valid_o=1, result_o=0xFFFFFFFF, no mdu_start_o; REMU 100%0 -> result_o=100.
REQ-034 MULHU 0x80000000*2 then identical request -> second returns 1 same cycle, no start.
REQ-035 flush_i in WAIT with busy high -> DRAIN, new req stalled until busy low, then normal issue; cache unchanged.
REQ-036 busy never falls -> timeout_o at cycle MAX_LAT, result_o=0, not cached.
REQ-037 hold_i=1 in DONE for 4 cycles -> valid_o and result_o stable, no restart.
